// File: rtl/step_sequencer.sv
// Looping note-pattern sequencer with edit, play (fixed tempo) and raw pass-through modes.
// Optional build macro SEQ_CLEAR_EN adds a clr input that wipes the pattern while editing.
module step_sequencer #(
    parameter int NUM_STEPS      = 8,
    parameter int NOTE_W         = 4,
    parameter int TICKS_PER_STEP = 12000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   mode,
    input  logic                         step_next,
    input  logic                         step_prev,
    input  logic                         note_wr,
`ifdef SEQ_CLEAR_EN
    input  logic                         clr,
`endif
    input  logic [NOTE_W-1:0]            note_in,
    input  logic [NOTE_W-1:0]            raw_note,
    output logic [NOTE_W-1:0]            note_out,
    output logic                         note_on,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         step_tick
);
    localparam int IDX_W  = $clog2(NUM_STEPS);
    localparam int TICK_W = $clog2(TICKS_PER_STEP);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

    typedef enum logic [1:0] {
        MODE_EDIT     = 2'd0,
        MODE_PLAY     = 2'd1,
        MODE_RAW      = 2'd2,
        MODE_EDIT_ALT = 2'd3
    } mode_e;

    logic [NOTE_W-1:0] mem_q [NUM_STEPS];
    logic [NOTE_W-1:0] mem_d [NUM_STEPS];
    logic [IDX_W-1:0]  step_idx_q,  step_idx_d;
    logic [TICK_W-1:0] tick_cnt_q,  tick_cnt_d;
    logic [NOTE_W-1:0] note_out_q,  note_out_d;
    logic              step_tick_q, step_tick_d;
    logic              note_on_q;
    mode_e             mode_q,      mode_d;
    logic              entering_play;

    assign mode_d        = mode_e'(mode);
    assign entering_play = (mode_d == MODE_PLAY) && (mode_q != MODE_PLAY);

    always_comb begin
        // NOTE: every _d signal gets a default before any branch, so no latch can be inferred.
        mem_d       = mem_q;
        step_idx_d  = step_idx_q;
        tick_cnt_d  = '0;
        note_out_d  = mem_q[step_idx_q];
        step_tick_d = 1'b0;

        case (mode_d)
            MODE_PLAY: begin
                if (entering_play) begin
                    step_idx_d = '0;
                end else if (tick_cnt_q == TICK_LAST) begin
                    step_idx_d  = step_idx_q + IDX_ONE;
                    step_tick_d = 1'b1;
                end else begin
                    tick_cnt_d = tick_cnt_q + TICK_ONE;
                end
            end
            MODE_RAW: begin
                note_out_d = raw_note;
            end
            default: begin
`ifdef SEQ_CLEAR_EN
                if (clr) begin
                    for (int i = 0; i < NUM_STEPS; i++) mem_d[i] = '0;
                    step_idx_d = '0;
                    note_out_d = '0;
                end else begin
`endif
                    // Write lands on the cursor position as it was before any move this cycle.
                    if (note_wr) begin
                        mem_d[step_idx_q] = note_in;
                        note_out_d        = note_in;
                    end
                    if (step_next && !step_prev) begin
                        step_idx_d = step_idx_q + IDX_ONE;
                    end else if (step_prev && !step_next) begin
                        step_idx_d = step_idx_q - IDX_ONE;
                    end
`ifdef SEQ_CLEAR_EN
                end
`endif
            end
        endcase
    end

    // NOTE: the pattern is only a few flops, so it is cleared by reset along with the rest
    //       of the state instead of being left as an unreset RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STEPS; i++) mem_q[i] <= '0;
            step_idx_q  <= '0;
            tick_cnt_q  <= '0;
            note_out_q  <= '0;
            note_on_q   <= 1'b0;
            step_tick_q <= 1'b0;
            mode_q      <= MODE_EDIT;
        end else begin
            // NOTE: non-blocking only, so every register samples the pre-edge values.
            mem_q       <= mem_d;
            step_idx_q  <= step_idx_d;
            tick_cnt_q  <= tick_cnt_d;
            note_out_q  <= note_out_d;
            note_on_q   <= (note_out_d != '0);
            step_tick_q <= step_tick_d;
            mode_q      <= mode_d;
        end
    end

    assign note_out  = note_out_q;
    assign note_on   = note_on_q;
    assign step_idx  = step_idx_q;
    assign step_tick = step_tick_q;

endmodule
